// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch time counter: default moduli/widths and
// the count-direction encoding used by the counter stages.
package stopwatch_pkg;
  localparam int SEC_MOD_DEF = 60;
  localparam int MIN_MOD_DEF = 100;
  localparam int SEC_W_DEF   = 6;
  localparam int MIN_W_DEF   = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/mod_updown_counter.sv
// Generic modulo-MOD up/down counter stage. The carry and borrow outputs are
// combinational so that a following stage can step on the same edge.
module mod_updown_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         dir,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] val,
  output logic         carry,
  output logic         borrow
);
  localparam logic [W-1:0] MAX = W'(MOD - 1);

  logic [W-1:0] val_q, val_d;

  assign val    = val_q;
  assign carry  = step && (dir == DIR_UP)   && (val_q == MAX);
  assign borrow = step && (dir == DIR_DOWN) && (val_q == '0);

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (ld) begin
      val_d = ld_val;
    end else if (step) begin
      if (dir == DIR_DOWN) begin
        val_d = (val_q == '0) ? MAX : val_q - W'(1);
      end else begin
        val_d = (val_q == MAX) ? '0 : val_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end
endmodule

// File: rtl/stopwatch_time_counter.sv
// Minutes:seconds stopwatch/timer counter built from two modulo stages, with
// load clamping, down-count saturation at 00:00 and wrap/done pulses.
// Optional lap snapshot registers are enabled with `define STOPWATCH_LAP_EN.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int SEC_MOD = SEC_MOD_DEF,
  parameter int MIN_MOD = MIN_MOD_DEF,
  parameter int SEC_W   = SEC_W_DEF,
  parameter int MIN_W   = MIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick,
  input  logic             count_down,
  input  logic             clear,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
`ifdef STOPWATCH_LAP_EN
  input  logic             lap,
  output logic [MIN_W-1:0] lap_min,
  output logic [SEC_W-1:0] lap_sec,
  output logic             lap_valid,
`endif
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             wrap,
  output logic             done,
  output logic             is_zero
);
  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_MOD - 1);
  localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MIN_MOD - 1);

  logic [SEC_W-1:0] sec_val, sec_ld;
  logic [MIN_W-1:0] min_val, min_ld;
  logic             sec_carry, sec_borrow, min_carry, min_borrow;
  logic             step_en, min_step;
  logic             wrap_q, wrap_d, done_q, done_d;

  assign sec_ld = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
  assign min_ld = (load_min > MIN_MAX) ? MIN_MAX : load_min;

  assign is_zero = (min_val == '0) && (sec_val == '0);

  // clear/load swallow a coincident tick; a down-count parks at 00:00.
  assign step_en  = enable && tick && !clear && !load && !(count_down && is_zero);
  assign min_step = sec_carry || sec_borrow;

  mod_updown_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .step   (step_en),
    .dir    (count_down),
    .clr    (clear),
    .ld     (load),
    .ld_val (sec_ld),
    .val    (sec_val),
    .carry  (sec_carry),
    .borrow (sec_borrow)
  );

  mod_updown_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk    (clk),
    .rst    (rst),
    .step   (min_step),
    .dir    (count_down),
    .clr    (clear),
    .ld     (load),
    .ld_val (min_ld),
    .val    (min_val),
    .carry  (min_carry),
    .borrow (min_borrow)
  );

  always_comb begin
    wrap_d = min_carry;
    done_d = step_en && (count_down == DIR_DOWN) && (min_val == '0)
             && (sec_val == SEC_W'(1)) && !min_borrow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign minutes = min_val;
  assign seconds = sec_val;
  assign wrap    = wrap_q;
  assign done    = done_q;

`ifdef STOPWATCH_LAP_EN
  logic [MIN_W-1:0] lap_min_q;
  logic [SEC_W-1:0] lap_sec_q;
  logic             lap_valid_q;

  // Snapshot uses the pre-step count, so a lap on a tick edge shows the old time.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
      lap_valid_q <= 1'b0;
    end else if (clear) begin
      lap_valid_q <= 1'b0;
    end else if (lap) begin
      lap_min_q   <= min_val;
      lap_sec_q   <= sec_val;
      lap_valid_q <= 1'b1;
    end
  end

  assign lap_min   = lap_min_q;
  assign lap_sec   = lap_sec_q;
  assign lap_valid = lap_valid_q;
`endif
endmodule
